// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared FSM encodings, RAM geometry and RW pin levels for RAM controllers
package ram_ctrl_pkg;
   localparam int RAM_AW = 4;
   localparam int RAM_DW = 8;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;
   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick, a tie goes to the port that did not win last
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic gnt
);
   assign valid = req0 | req1;
   assign gnt   = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/ram_arbiter_rr.sv
// ram_arbiter_rr: round-robin sharing of one single-port synchronous RAM between two requesters
module ram_arbiter_rr
   import ram_ctrl_pkg::*;
#(
   parameter int AW = RAM_AW,
   parameter int DW = RAM_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rw,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          busy
);
   logic [1:0]    state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          last_q, last_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          pick_valid, pick_gnt;
   logic          sel_we, in_access, rd_cap;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   rr_pick2 u_pick (
      .req0  (req0),
      .req1  (req1),
      .last  (last_q),
      .valid (pick_valid),
      .gnt   (pick_gnt)
   );

   // Requests are held until ack, so the granted port's pins stay valid through ACCESS and RESP
   always_comb begin
      sel_we    = gnt_q ? we1 : we0;
      sel_addr  = gnt_q ? addr1 : addr0;
      sel_wdata = gnt_q ? wdata1 : wdata0;
      in_access = state_q == ACCESS;
      rd_cap    = (state_q == RESP) && (sel_we == RW_READ);
      state_d   = (state_q == IDLE) ? (pick_valid ? ACCESS : IDLE) : in_access ? RESP : IDLE;
      gnt_d     = (state_q == IDLE && pick_valid) ? pick_gnt : gnt_q;
      last_d    = in_access ? gnt_q : last_q;
      rdata0_d  = (rd_cap && !gnt_q) ? ram_rdata : rdata0_q;
      rdata1_d  = (rd_cap && gnt_q) ? ram_rdata : rdata1_q;
   end

   // RAM pins are decoded from state so an async reset drops a pending write at once
   always_comb begin
      ram_rw    = in_access && (sel_we == RW_WRITE);
      ram_addr  = in_access ? sel_addr : '0;
      ram_wdata = in_access ? sel_wdata : '0;
      ack0      = (state_q == RESP) && !gnt_q;
      ack1      = (state_q == RESP) && gnt_q;
      rdata0    = (rd_cap && !gnt_q) ? ram_rdata : rdata0_q;
      rdata1    = (rd_cap && gnt_q) ? ram_rdata : rdata1_q;
      busy      = state_q != IDLE;
   end

   // State, grant, fairness history and per-port read data; last resets to 1 so port 0 wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end
endmodule
